dbg_scan_ctrl: RTL and testbench

DBG_SCAN_CTRL -- requirements
Module: dbg_scan_ctrl

---
 rtl/dbg_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dbg_scan_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dbg_scan_ctrl                                              |
// | Description : Debug scan controller: divider tick, run/halt/step CPU     |
// |               clock enable, and a channel address scanner with display.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dbg_scan_ctrl #(
    parameter int NCH      = 4,
    parameter int DW       = 32,
    parameter int AW       = 6,
    parameter int FAST_BIT = 25,
    parameter int SLOW_BIT = 27
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              slow_i,
    input  logic              run_i,
    input  logic              step_i,
    input  logic [NCH-1:0]    ch_en_i,
    input  logic [NCH*AW-1:0] ch_last_i,
    input  logic [NCH*DW-1:0] ch_rdata_i,
    output logic [NCH*AW-1:0] ch_addr_o,
    output logic              cpu_ce_o,
    output logic              tick_o,
    output logic [DW-1:0]     disp_data_o,
    output logic [2:0]        disp_ch_o
);

    localparam logic [1:0]          c_ST_HALT = 2'd0;
    localparam logic [1:0]          c_ST_RUN  = 2'd1;
    localparam logic [1:0]          c_ST_STEP = 2'd2;
    localparam logic [SLOW_BIT:0]   c_DIV_ONE = 1;
    localparam logic [AW-1:0]       c_ADDR_ONE = 1;

    logic [SLOW_BIT:0] r_div;
    logic              r_fast_d;
    logic              r_slow_d;
    logic              r_tick;
    logic              w_tick_nxt;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_sync3;
    logic              w_step_p;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [2:0]        w_sel;
    logic              w_any;
    logic [DW-1:0]     w_rdata;
    logic [DW-1:0]     r_disp_data;
    logic [2:0]        r_disp_ch;

    // Both bit histories are tracked continuously so switching slow_i can
    // never synthesise an edge that the newly selected bit did not make.
    assign w_tick_nxt = slow_i ? (r_div[SLOW_BIT] & ~r_slow_d)
                               : (r_div[FAST_BIT] & ~r_fast_d);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div    <= '0;
            r_fast_d <= 1'b0;
            r_slow_d <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_div    <= r_div + c_DIV_ONE;
            r_fast_d <= r_div[FAST_BIT];
            r_slow_d <= r_div[SLOW_BIT];
            r_tick   <= w_tick_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= step_i;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_step_p = r_sync2 & ~r_sync3;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_HALT: begin
                if (run_i)
                    w_state_nxt = c_ST_RUN;
                else if (w_step_p)
                    w_state_nxt = c_ST_STEP;
            end
            c_ST_RUN: begin
                if (!run_i)
                    w_state_nxt = c_ST_HALT;
            end
            default: w_state_nxt = c_ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= c_ST_HALT;
        else
            r_state <= w_state_nxt;
    end

    // Decoded from flops only, so the async clear removes it immediately.
    assign cpu_ce_o = ((r_state == c_ST_RUN) & r_tick) | (r_state == c_ST_STEP);
    assign tick_o   = r_tick;

    always_comb begin
        w_sel = 3'd0;
        w_any = |ch_en_i;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (ch_en_i[k])
                w_sel = 3'(k);
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_sel == 3'(k))
                w_rdata = ch_rdata_i[k*DW +: DW];
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [AW-1:0] w_last;
        logic [AW-1:0] r_addr;

        assign w_last = ch_last_i[k*AW +: AW];

        // ">=" also catches a limit lowered below the current address.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)
                r_addr <= '0;
            else if (r_tick && w_any && (w_sel == 3'(k)))
                r_addr <= (r_addr >= w_last) ? '0 : r_addr + c_ADDR_ONE;
        end

        assign ch_addr_o[k*AW +: AW] = r_addr;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_disp_data <= '0;
            r_disp_ch   <= 3'd0;
        end else begin
            r_disp_data <= w_rdata;
            r_disp_ch   <= w_sel;
        end
    end

    assign disp_data_o = r_disp_data;
    assign disp_ch_o   = r_disp_ch;

endmodule
`default_nettype wire

// File: tb/tb_dbg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dbg_scan_ctrl                                           |
// | Description : Scoreboard bench for dbg_scan_ctrl with directed vectors.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dbg_scan_ctrl;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int AW  = 6;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              slow_i = 1'b0;
    logic              run_i = 1'b0;
    logic              step_i = 1'b0;
    logic [NCH-1:0]    ch_en_i = '0;
    logic [NCH*AW-1:0] ch_last_i = '1;
    logic [NCH*DW-1:0] ch_rdata_i;
    logic [NCH*AW-1:0] ch_addr_o;
    logic              cpu_ce_o;
    logic              tick_o;
    logic [DW-1:0]     disp_data_o;
    logic [2:0]        disp_ch_o;

    dbg_scan_ctrl #(
        .NCH(NCH), .DW(DW), .AW(AW), .FAST_BIT(2), .SLOW_BIT(4)
    ) u_dut (
        .clk(clk), .rstn(rstn), .slow_i(slow_i), .run_i(run_i), .step_i(step_i),
        .ch_en_i(ch_en_i), .ch_last_i(ch_last_i), .ch_rdata_i(ch_rdata_i),
        .ch_addr_o(ch_addr_o), .cpu_ce_o(cpu_ce_o), .tick_o(tick_o),
        .disp_data_o(disp_data_o), .disp_ch_o(disp_ch_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd_word(input int k, input logic [5:0] a);
        return 32'hC0DE_0000 | (32'(k) << 8) | {26'd0, a};
    endfunction

    always_comb begin
        ch_rdata_i = '0;
        for (int k = 0; k < NCH; k++)
            ch_rdata_i[k*DW +: DW] = rd_word(k, ch_addr_o[k*AW +: AW]);
    end

    typedef struct packed {
        logic [31:0] cyc;
        logic        tick;
        logic        ce;
        logic [23:0] addr;
        logic [2:0]  dch;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk = 0;
    int  n_pass = 0;

    function automatic logic [23:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    endfunction

    task automatic push(input int unsigned c, input logic t, input logic e,
                        input logic [23:0] a, input int ch, input int asel);
        ev_t ev;
        ev.cyc  = c;
        ev.tick = t;
        ev.ce   = e;
        ev.addr = a;
        ev.dch  = 3'(ch);
        ev.data = rd_word(ch, 6'(asel));
        exp_q.push_back(ev);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Every cycle with a tick or CE pulse must match the next queued event.
    always @(negedge clk) begin
        ev_t act;
        ev_t e;
        if (rstn && (tick_o || cpu_ce_o)) begin
            act = {cyc, tick_o, cpu_ce_o, ch_addr_o, disp_ch_o, disp_data_o};
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL event: unexpected pulse at cyc=%0d tick=%b ce=%b addr=%h",
                         cyc, tick_o, cpu_ce_o, ch_addr_o);
            end else begin
                e = exp_q.pop_front();
                if (act == e)
                    n_pass++;
                else
                    $display("FAIL event: got cyc=%0d tick=%b ce=%b addr=%h ch=%0d data=%h want cyc=%0d tick=%b ce=%b addr=%h ch=%0d data=%h",
                             act.cyc, act.tick, act.ce, act.addr, act.dch, act.data,
                             e.cyc, e.tick, e.ce, e.addr, e.dch, e.data);
            end
        end
    end

    task automatic wait_cyc(input int unsigned n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; slow_i = 1'b0; run_i = 1'b0; step_i = 1'b0;
        ch_en_i = '0; ch_last_i = '1;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain(input string nm);
        chk(nm, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned r;

        @(negedge clk);
        chk("rst_ce",   64'(cpu_ce_o),    64'd0);
        chk("rst_tick", 64'(tick_o),      64'd0);
        chk("rst_data", 64'(disp_data_o), 64'd0);
        chk("rst_ch",   64'(disp_ch_o),   64'd0);
        chk("rst_addr", 64'(ch_addr_o),   64'd0);

        // Wrap of channel 2 at last=6, fast tick period 8
        do_reset();
        ch_en_i = 4'b0100;
        ch_last_i[2*AW +: AW] = 6'd6;
        rstn = 1'b1; r = cyc;
        for (int k = 0; k < 8; k++)
            push(r + 5 + 8*k, 1'b1, 1'b0, pk(0, 0, k % 7, 0), 2, k % 7);
        wait_cyc(r + 63);
        drain("wrap_drain");

        // Slow ticks, then toggles of slow_i with no extra pulses
        do_reset();
        slow_i = 1'b1;
        rstn = 1'b1; r = cyc;
        push(r + 17, 1'b1, 1'b0, pk(0, 0, 0, 0), 0, 0);
        push(r + 49, 1'b1, 1'b0, pk(0, 0, 0, 0), 0, 0);
        push(r + 53, 1'b1, 1'b0, pk(0, 0, 0, 0), 0, 0);
        push(r + 81, 1'b1, 1'b0, pk(0, 0, 0, 0), 0, 0);
        wait_cyc(r + 50); slow_i = 1'b0;
        wait_cyc(r + 57); slow_i = 1'b1;
        wait_cyc(r + 83);
        drain("slow_drain");

        // Single step while halted: one CE three clocks after the edge
        do_reset();
        rstn = 1'b1; r = cyc;
        push(r + 5,  1'b1, 1'b0, pk(0, 0, 0, 0), 0, 0);
        push(r + 9,  1'b0, 1'b1, pk(0, 0, 0, 0), 0, 0);
        push(r + 13, 1'b1, 1'b0, pk(0, 0, 0, 0), 0, 0);
        push(r + 21, 1'b1, 1'b0, pk(0, 0, 0, 0), 0, 0);
        push(r + 29, 1'b1, 1'b0, pk(0, 0, 0, 0), 0, 0);
        wait_cyc(r + 6);  step_i = 1'b1;
        wait_cyc(r + 26); step_i = 1'b0;
        wait_cyc(r + 31);
        drain("step_drain");

        // Run mode with priority select, resume, freeze and reset mid-run
        do_reset();
        run_i = 1'b1; ch_en_i = 4'b1010;
        rstn = 1'b1; r = cyc;
        push(r + 5,  1'b1, 1'b1, pk(0, 0, 0, 0), 1, 0);
        push(r + 13, 1'b1, 1'b1, pk(0, 1, 0, 0), 1, 1);
        push(r + 21, 1'b1, 1'b1, pk(0, 2, 0, 0), 1, 2);
        push(r + 29, 1'b1, 1'b1, pk(0, 3, 0, 0), 3, 0);
        push(r + 37, 1'b1, 1'b1, pk(0, 3, 0, 1), 3, 1);
        push(r + 45, 1'b1, 1'b1, pk(0, 3, 0, 2), 1, 3);
        push(r + 53, 1'b1, 1'b1, pk(0, 4, 0, 2), 1, 4);
        push(r + 61, 1'b1, 1'b1, pk(0, 5, 0, 2), 0, 0);
        wait_cyc(r + 24);
        chk("sel_before", 64'(disp_ch_o), 64'd1);
        ch_en_i = 4'b1000;
        wait_cyc(r + 25);
        chk("sel_ch3",   64'(disp_ch_o),   64'd3);
        chk("sel_data3", 64'(disp_data_o), 64'(rd_word(3, 6'd0)));
        wait_cyc(r + 30); step_i = 1'b1;
        wait_cyc(r + 38); ch_en_i = 4'b0010;
        wait_cyc(r + 39);
        chk("resume_addr", 64'(ch_addr_o), 64'(pk(0, 3, 0, 2)));
        wait_cyc(r + 40); step_i = 1'b0;
        wait_cyc(r + 56); ch_en_i = 4'b0000;
        wait_cyc(r + 63);
        chk("freeze_addr", 64'(ch_addr_o), 64'(pk(0, 5, 0, 2)));
        chk("freeze_ch",   64'(disp_ch_o), 64'd0);
        wait_cyc(r + 68);
        @(posedge clk); #1;
        chk("pre_rst_ce",   64'(cpu_ce_o), 64'd1);
        chk("pre_rst_tick", 64'(tick_o),   64'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_ce",   64'(cpu_ce_o),    64'd0);
        chk("mid_rst_tick", 64'(tick_o),      64'd0);
        chk("mid_rst_addr", 64'(ch_addr_o),   64'd0);
        chk("mid_rst_ch",   64'(disp_ch_o),   64'd0);
        chk("mid_rst_data", 64'(disp_data_o), 64'd0);
        drain("run_drain");

        // After reset: halted, divider restarted, then a short run window
        run_i = 1'b0; step_i = 1'b0; ch_en_i = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1; r = cyc;
        push(r + 5,  1'b1, 1'b0, pk(0, 0, 0, 0), 0, 0);
        push(r + 13, 1'b1, 1'b1, pk(0, 0, 0, 0), 0, 0);
        push(r + 21, 1'b1, 1'b0, pk(0, 0, 0, 0), 0, 0);
        wait_cyc(r + 7);  run_i = 1'b1;
        wait_cyc(r + 14); run_i = 1'b0;
        wait_cyc(r + 23);
        drain("post_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
